// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one pipelined fp_mul among N requesters; gnt is combinational, rsp_valid follows its grant by exactly LAT cycles.
// No backpressure: a product is lost if the requester does not take it in its rsp_valid cycle. FP_MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module fp_mul_arbiter #(
  parameter  int N    = 4,
  parameter  int LAT  = 5,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          sreset,
  input  logic [N-1:0]  req,
  input  logic [31:0]   a_in [N],
  input  logic [31:0]   b_in [N],
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  rsp_valid,
  output logic [31:0]   rsp_data,
  output logic [31:0]   fpu_a,
  output logic [31:0]   fpu_b,
  output logic          fpu_areset,
  input  logic [31:0]   fpu_q,
  output logic          busy
);

  typedef struct packed {
    logic            vld;
    logic [IDXW-1:0] idx;
  } tag_t;

  tag_t            tag_q [LAT];
  tag_t            tag_d [LAT];
  logic            gnt_vld;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] cand;

`ifndef FP_MUL_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;
`endif

  // Scan from the pointer upward, wrapping at N-1; first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    fpu_a   = 32'h0;
    fpu_b   = 32'h0;
    if (!sreset) begin
      for (int k = 0; k < N; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        cand = IDXW'(k);
`else
        cand = IDXW'((int'(ptr_q) + k) % N);
`endif
        if (!gnt_vld && req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      fpu_a        = a_in[gnt_idx];
      fpu_b        = b_in[gnt_idx];
    end
  end

`ifndef FP_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = IDXW'((int'(gnt_idx) + 1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Tag shadow of the fp_mul pipeline: the last stage names the owner of fpu_q.
  always_comb begin
    tag_d[0] = tag_t'{vld: gnt_vld, idx: gnt_idx};
    for (int s = 1; s < LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      busy = busy | tag_q[s].vld;
    end
    for (int i = 0; i < N; i++) begin
      rsp_valid[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].idx == IDXW'(i));
    end
  end

  assign rsp_data   = fpu_q;
  assign fpu_areset = sreset;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter (N=4, LAT=5) with a small fp_mul stand-in.
module tb_fp_mul_arbiter;
  localparam int N   = 4;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         sreset;
  logic [N-1:0] req;
  logic [31:0]  a_in [N];
  logic [31:0]  b_in [N];
  logic [N-1:0] gnt;
  logic [N-1:0] rsp_valid;
  logic [31:0]  rsp_data;
  logic [31:0]  fpu_a;
  logic [31:0]  fpu_b;
  logic         fpu_areset;
  logic [31:0]  fpu_q;
  logic         busy;

  logic [31:0]  pipe [LAT];
  logic [31:0]  exp_prod [N];
  logic [31:0]  exp_a [N];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk        (clk),
    .sreset     (sreset),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_areset (fpu_areset),
    .fpu_q      (fpu_q),
    .busy       (busy)
  );

  // Products for the operand pairs used below; anything else yields a^b.
  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    case (ab)
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3F00_0000, 32'h4080_0000}: return 32'h4000_0000;
      default:                        return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (fpu_areset) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= 32'h0;
    end else begin
      pipe[0] <= mul_ref(fpu_a, fpu_b);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign fpu_q = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    req    = 4'b1111;
    repeat (2) begin
      tick();
      #2;
      chk("rst_gnt", {28'h0, gnt}, 32'h0);
      chk("rst_fpu_a", fpu_a, 32'h0);
      chk("rst_fpu_b", fpu_b, 32'h0);
    end
    tick();
    sreset = 1'b0;
    req    = 4'b0000;
    #2;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp", {28'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [3:0] e;
    sreset = 1'b1;
    req    = '0;
    a_in[0] = 32'h3F80_0000; b_in[0] = 32'h3F80_0000;
    a_in[1] = 32'h4000_0000; b_in[1] = 32'h4000_0000;
    a_in[2] = 32'h4000_0000; b_in[2] = 32'h4040_0000;
    a_in[3] = 32'h3F00_0000; b_in[3] = 32'h4080_0000;
    exp_a[0] = 32'h3F80_0000; exp_prod[0] = 32'h3F80_0000;
    exp_a[1] = 32'h4000_0000; exp_prod[1] = 32'h4080_0000;
    exp_a[2] = 32'h4000_0000; exp_prod[2] = 32'h40C0_0000;
    exp_a[3] = 32'h3F00_0000; exp_prod[3] = 32'h4000_0000;

    do_reset();

    // single request: 2.0 * 3.0 on requester 2
    tick();
    req = 4'b0100;
    #2;
    chk("single_gnt", {28'h0, gnt}, 32'h4);
    chk("single_fpu_a", fpu_a, 32'h4000_0000);
    chk("single_fpu_b", fpu_b, 32'h4040_0000);
    chk("single_busy0", {31'h0, busy}, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      req = 4'b0000;
      #2;
      chk("single_busy", {31'h0, busy}, (k <= LAT) ? 32'h1 : 32'h0);
      chk("single_rsp", {28'h0, rsp_valid}, (k == LAT) ? 32'h4 : 32'h0);
      if (k == LAT) chk("single_data", rsp_data, 32'h40C0_0000);
    end

    // idle
    for (int k = 0; k < 20; k++) begin
      tick();
      req = 4'b0000;
      #2;
      chk("idle_gnt", {28'h0, gnt}, 32'h0);
      chk("idle_fpu_a", fpu_a, 32'h0);
      chk("idle_fpu_b", fpu_b, 32'h0);
      chk("idle_rsp", {28'h0, rsp_valid}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end

    // one requester back-to-back; grant and response coincide from cycle LAT on
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      req = 4'b0001;
      #2;
      chk("b2b_gnt", {28'h0, gnt}, 32'h1);
      chk("b2b_rsp", {28'h0, rsp_valid}, (k >= LAT) ? 32'h1 : 32'h0);
      if (k >= LAT) chk("b2b_data", rsp_data, 32'h3F80_0000);
    end

    // reset with two products in flight
    do_reset();
    tick();
    req = 4'b0001;
    #2;
    chk("mid_gnt0", {28'h0, gnt}, 32'h1);
    tick();
    req = 4'b0010;
    #2;
    chk("mid_gnt1", {28'h0, gnt}, 32'h2);
    tick();
    sreset = 1'b1;
    req    = 4'b1111;
    #2;
    chk("mid_rst_gnt", {28'h0, gnt}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      sreset = 1'b0;
      req    = 4'b0000;
      #2;
      chk("mid_rsp", {28'h0, rsp_valid}, 32'h0);
      chk("mid_busy", {31'h0, busy}, 32'h0);
    end
    tick();
    req = 4'b1111;
    #2;
    chk("mid_first_gnt", {28'h0, gnt}, 32'h1);

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      req = 4'b0011;
      #2;
      chk("fixed_gnt", {28'h0, gnt}, 32'h1);
    end
`else
    // pointer after a skipped requester
    do_reset();
    tick();
    req = 4'b1010;
    #2;
    chk("skip_gnt1", {28'h0, gnt}, 32'h2);
    tick();
    req = 4'b1011;
    #2;
    chk("skip_gnt3", {28'h0, gnt}, 32'h8);
    tick();
    #2;
    chk("skip_gnt0", {28'h0, gnt}, 32'h1);

    // all four requesting continuously
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      req = 4'b1111;
      #2;
      e = 4'b0001 << (k % 4);
      chk("rr_gnt", {28'h0, gnt}, {28'h0, e});
      chk("rr_fpu_a", fpu_a, exp_a[k % 4]);
      chk("rr_busy", {31'h0, busy}, (k >= 1) ? 32'h1 : 32'h0);
      if (k >= LAT) begin
        e = 4'b0001 << ((k - LAT) % 4);
        chk("rr_rsp", {28'h0, rsp_valid}, {28'h0, e});
        chk("rr_data", rsp_data, exp_prod[(k - LAT) % 4]);
      end else begin
        chk("rr_rsp_early", {28'h0, rsp_valid}, 32'h0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
